// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and types for the VGA raster timing generator.
//   DEF_* are the 640x480@60 Hz defaults; the derived totals and sync
//   windows below describe that default mode.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // Inclusive window test on a raster coordinate.
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
//   DEPTH-stage shift register, every stage resets to all ones so that
//   active-low syncs read inactive out of reset. DEPTH = 0 is a plain wire.
// Ports:
//   vga_clk  in   pixel clock
//   reset_n  in   asynchronous active-low reset
//   din      in   WIDTH-bit input
//   dout     out  din delayed DEPTH cycles
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = vga_clk ^ reset_n;
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage;

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage <= '1;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 Hz raster timing from the 25 MHz pixel clock.
//   DrawX/DrawY/blank/frame_start/vblank_start are registered from the
//   next-state counters so they share one edge. hs/vs are registered and then
//   delayed SYNC_DELAY cycles to line up with the sprite renderers' colour
//   register. Reset release is expected to be synchronous to vga_clk; the
//   first edge after release presents pixel (0,0).
//   Optional macro VGA_ANIM_TICK_EN enables the animation frame divider;
//   without it anim_frame/anim_tick are tied to 0.
// Ports:
//   vga_clk       in   pixel clock
//   reset_n       in   asynchronous active-low reset
//   DrawX/DrawY   out  current column / line
//   blank         out  1 = active video
//   hs/vs         out  active-low syncs, delayed SYNC_DELAY cycles
//   frame_start   out  pulse at (0,0)
//   vblank_start  out  pulse at (0,V_VISIBLE)
//   anim_frame    out  animation index 0..3
//   anim_tick     out  pulse when anim_frame changes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = 1,
    parameter int ANIM_DIV   = 8
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [1:0] anim_frame,
    output logic       anim_tick
);

    localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_VISIBLE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    generate
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4 || ANIM_DIV < 1) begin : g_bad_param
            $error("vga_timing_gen: SYNC_DELAY must be 0..4 and ANIM_DIV >= 1");
        end
    endgenerate

    coord_t     h_cnt, v_cnt, h_nxt, v_nxt;
    logic       h_wrap, vbs_nxt;
    logic       hs_raw_q, vs_raw_q;
    logic [1:0] sync_q;

    always_comb begin
        h_wrap  = (h_cnt == coord_t'(H_TOT - 1));
        h_nxt   = h_wrap ? '0 : h_cnt + coord_t'(1);
        v_nxt   = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == coord_t'(V_TOT - 1)) ? '0 : v_cnt + coord_t'(1);
        end
        vbs_nxt = (h_nxt == '0) && (v_nxt == coord_t'(V_VISIBLE));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt        <= coord_t'(H_TOT - 1);
            v_cnt        <= coord_t'(V_TOT - 1);
            blank        <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            hs_raw_q     <= 1'b1;
            vs_raw_q     <= 1'b1;
        end else begin
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            blank        <= (h_nxt < coord_t'(H_VISIBLE)) && (v_nxt < coord_t'(V_VISIBLE));
            frame_start  <= (h_nxt == '0) && (v_nxt == '0);
            vblank_start <= vbs_nxt;
            hs_raw_q     <= !in_range(h_nxt, coord_t'(HS_FIRST), coord_t'(HS_LAST));
            vs_raw_q     <= !in_range(v_nxt, coord_t'(VS_FIRST), coord_t'(VS_LAST));
        end
    end

    assign DrawX = h_cnt;
    assign DrawY = v_cnt;

    // hs_raw_q/vs_raw_q already line up with DrawX, so DEPTH = SYNC_DELAY.
    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (2)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     ({hs_raw_q, vs_raw_q}),
        .dout    (sync_q)
    );

    assign hs = sync_q[1];
    assign vs = sync_q[0];

`ifdef VGA_ANIM_TICK_EN
    localparam int FW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [FW-1:0] frm_cnt;
    logic          frm_wrap;

    assign frm_wrap = (frm_cnt == FW'(ANIM_DIV - 1));

    // Advances on the same edge that raises vblank_start, so anim_frame
    // only ever changes inside vertical blanking.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_cnt    <= '0;
            anim_frame <= '0;
            anim_tick  <= 1'b0;
        end else begin
            anim_tick <= vbs_nxt && frm_wrap;
            if (vbs_nxt) begin
                if (frm_wrap) begin
                    frm_cnt    <= '0;
                    anim_frame <= anim_frame + 2'd1;
                end else begin
                    frm_cnt <= frm_cnt + FW'(1);
                end
            end
        end
    end
`else
    assign anim_frame = 2'd0;
    assign anim_tick  = 1'b0;
`endif

endmodule
